idex_stage: RTL and testbench

- Decode-to-execute pipeline register of the rvpipe core, directly downstream of the register file.
- Captures the two register-file read operands plus decode fields each cycle and presents them to the execute stage.
- Supports stall (hold) and flush (bubble insertion).
- Keeps held operands coherent with writebacks that land while the stage is stalled. The register file writes on the falling edge, so a value held across a stall would otherwise go stale.

---
 rtl/idex_stage.sv | 146 ++++++++++++++
 tb/tb_idex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// -----------------------------------------------------------------------------
// idex_stage: decode-to-execute pipeline register of the rvpipe core.
//
// Captures the register-file read operands and the decode fields every cycle
// and presents them to the execute stage one cycle later. Supports stall
// (hold) and flush (bubble). While stalled, the held operands track
// writebacks to their source registers. The register file commits on the
// falling edge, so without this tracking a held value would go stale.
//
// Ports:
//   clk, reset              core clock, asynchronous active-high reset
//   stall_e, flush_e        hold / bubble controls (flush has priority)
//   valid_d, ctrl_d         decode valid flag and opaque control bundle
//                           (ctrl bit 0 = regwrite)
//   pc_d, imm_d             instruction PC and extended immediate
//   rs1_d, rs2_d, rd_d      source / destination register addresses
//   rd1_d, rd2_d            register-file read data
//   wb_we, wb_rd, wb_wd     writeback port (same as regfile we3/a3/wd3)
//   *_e                     registered copies presented to execute
// -----------------------------------------------------------------------------
module idex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rd_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e
);

    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_X0 = REG_AW'(0);

    // next-state values of the stage register
    logic              valid_n;
    logic [CTRL_W-1:0] ctrl_n;
    logic [XLEN-1:0]   pc_n;
    logic [XLEN-1:0]   imm_n;
    logic [XLEN-1:0]   rd1_n;
    logic [XLEN-1:0]   rd2_n;
    logic [4:0]        rs1_n;
    logic [4:0]        rs2_n;
    logic [4:0]        rd_n;

    // writeback hits a held source operand (x0 is hardwired to zero, never patched)
    logic wb_live_c;
    logic patch1_c;
    logic patch2_c;

    always_comb begin
        wb_live_c = wb_we && (wb_rd != REG_X0) && valid_e;
        patch1_c  = wb_live_c && (wb_rd == rs1_e);
        patch2_c  = wb_live_c && (wb_rd == rs2_e);
    end

    // next-state selection: flush > stall (with operand patch) > load
    always_comb begin
        valid_n = valid_e;
        ctrl_n  = ctrl_e;
        pc_n    = pc_e;
        imm_n   = imm_e;
        rd1_n   = rd1_e;
        rd2_n   = rd2_e;
        rs1_n   = rs1_e;
        rs2_n   = rs2_e;
        rd_n    = rd_e;

        if (flush_e) begin
            valid_n = 1'b0;
            ctrl_n  = '0;
            pc_n    = '0;
            imm_n   = '0;
            rd1_n   = '0;
            rd2_n   = '0;
            rs1_n   = '0;
            rs2_n   = '0;
            rd_n    = '0;
        end else if (stall_e) begin
            // both operands may be patched by the same write
            if (patch1_c) begin
                rd1_n = wb_wd;
            end
            if (patch2_c) begin
                rd2_n = wb_wd;
            end
        end else begin
            // no bypass here: rd1_d/rd2_d already include this cycle's write
            valid_n = valid_d;
            ctrl_n  = valid_d ? ctrl_d : '0;
            pc_n    = pc_d;
            imm_n   = imm_d;
            rd1_n   = rd1_d;
            rd2_n   = rd2_d;
            rs1_n   = rs1_d;
            rs2_n   = rs2_d;
            rd_n    = rd_d;
        end
    end

    // stage register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_e <= 1'b0;
            ctrl_e  <= '0;
            pc_e    <= '0;
            imm_e   <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            rs1_e   <= '0;
            rs2_e   <= '0;
            rd_e    <= '0;
        end else begin
            valid_e <= valid_n;
            ctrl_e  <= ctrl_n;
            pc_e    <= pc_n;
            imm_e   <= imm_n;
            rd1_e   <= rd1_n;
            rd2_e   <= rd2_n;
            rs1_e   <= rs1_n;
            rs2_e   <= rs2_n;
            rd_e    <= rd_n;
        end
    end

endmodule

// File: tb/tb_idex_stage.sv
// -----------------------------------------------------------------------------
// tb_idex_stage: scoreboard bench for idex_stage.
// The reference keeps a 32-entry register file and the instruction held in
// execute. Whenever a valid instruction is held, its operands must equal the
// current register-file contents of its source registers.
// -----------------------------------------------------------------------------
module tb_idex_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall_e = 1'b0;
    logic              flush_e = 1'b0;
    logic              valid_d = 1'b0;
    logic [CTRL_W-1:0] ctrl_d = '0;
    logic [XLEN-1:0]   pc_d = '0;
    logic [XLEN-1:0]   imm_d = '0;
    logic [4:0]        rs1_d = '0;
    logic [4:0]        rs2_d = '0;
    logic [4:0]        rd_d = '0;
    logic [XLEN-1:0]   rd1_d = '0;
    logic [XLEN-1:0]   rd2_d = '0;
    logic              wb_we = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [XLEN-1:0]   wb_wd = '0;
    logic              valid_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   imm_e;
    logic [XLEN-1:0]   rd1_e;
    logic [XLEN-1:0]   rd2_e;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;

    always #5 clk = ~clk;

    idex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .ctrl_d(ctrl_d), .pc_d(pc_d), .imm_d(imm_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .valid_e(valid_e), .ctrl_e(ctrl_e), .pc_e(pc_e), .imm_e(imm_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    typedef struct {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } stage_t;

    stage_t        sb_q[$];
    stage_t        mdl;
    logic [XLEN-1:0] rf [32];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic cmp_stage(input string tag, input stage_t w);
        chk({tag, ".valid_e"}, XLEN'(valid_e), XLEN'(w.valid));
        chk({tag, ".ctrl_e"},  XLEN'(ctrl_e),  XLEN'(w.ctrl));
        chk({tag, ".pc_e"},    pc_e,           w.pc);
        chk({tag, ".imm_e"},   imm_e,          w.imm);
        chk({tag, ".rd1_e"},   rd1_e,          w.rd1);
        chk({tag, ".rd2_e"},   rd2_e,          w.rd2);
        chk({tag, ".rs1_e"},   XLEN'(rs1_e),   XLEN'(w.rs1));
        chk({tag, ".rs2_e"},   XLEN'(rs2_e),   XLEN'(w.rs2));
        chk({tag, ".rd_e"},    XLEN'(rd_e),    XLEN'(w.rd));
    endtask

    // monitor: one expected stage image per rising edge
    initial begin
        stage_t w;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                w = sb_q.pop_front();
                cmp_stage("edge", w);
            end
        end
    end

    // one cycle of stimulus; the register file commits on the falling edge,
    // so read data presented this cycle already reflects this cycle's write
    task automatic drive(input logic rst, input logic stl, input logic fl,
                         input logic v, input logic [CTRL_W-1:0] c,
                         input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                         input logic we, input logic [4:0] wrd, input logic [XLEN-1:0] wwd);
        @(negedge clk);
        if (we && wrd != 5'd0) rf[wrd] = wwd;
        reset   = rst;
        stall_e = stl;
        flush_e = fl;
        valid_d = v;
        ctrl_d  = c;
        pc_d    = p;
        imm_d   = im;
        rs1_d   = a1;
        rs2_d   = a2;
        rd_d    = ad;
        rd1_d   = rf[a1];
        rd2_d   = rf[a2];
        wb_we   = we;
        wb_rd   = wrd;
        wb_wd   = wwd;
        if (rst || fl) begin
            mdl = '{default: '0};
        end else if (stl) begin
            // a held real instruction stays coherent with the register file
            if (mdl.valid) begin
                mdl.rd1 = rf[mdl.rs1];
                mdl.rd2 = rf[mdl.rs2];
            end
        end else begin
            mdl.valid = v;
            mdl.ctrl  = v ? c : '0;
            mdl.pc    = p;
            mdl.imm   = im;
            mdl.rs1   = a1;
            mdl.rs2   = a2;
            mdl.rd    = ad;
            mdl.rd1   = rf[a1];
            mdl.rd2   = rf[a2];
        end
        sb_q.push_back(mdl);
    endtask

    task automatic load(input logic v, input logic [CTRL_W-1:0] c, input logic [XLEN-1:0] p,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        drive(1'b0, 1'b0, 1'b0, v, c, p, p + 32'h40, a1, a2, ad, 1'b0, 5'd0, '0);
    endtask

    task automatic stall_wb(input logic we, input logic [4:0] wrd, input logic [XLEN-1:0] wwd);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, we, wrd, wwd);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        mdl = '{default: '0};

        // reset, seeding the register file through the writeback port
        drive(1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF, 32'h1234, 32'h1, 5'd1, 5'd2, 5'd3, 1'b1, 5'd3, 32'hAAAA);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h11);

        // reset then load
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h0F1, 32'h100, 32'h8, 5'd3, 5'd4, 5'd9, 1'b0, 5'd0, '0);

        // flush, then flush together with stall
        drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h0AA, 32'h104, 32'h4, 5'd3, 5'd3, 5'd7, 1'b0, 5'd0, '0);
        load(1'b1, 12'h0F3, 32'h108, 5'd3, 5'd5, 5'd8);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h0AA, 32'h10C, 32'h4, 5'd3, 5'd3, 5'd7, 1'b0, 5'd0, '0);
        stall_wb(1'b1, 5'd3, 32'h5555);

        // stall patch of both operands by one write
        load(1'b1, 12'h0F5, 32'h110, 5'd5, 5'd5, 5'd6);
        stall_wb(1'b1, 5'd5, 32'hDEAD);

        // no-patch cases
        load(1'b1, 12'h0F7, 32'h114, 5'd0, 5'd0, 5'd1);
        stall_wb(1'b1, 5'd0, 32'h123);
        load(1'b1, 12'h0F9, 32'h118, 5'd5, 5'd6, 5'd1);
        stall_wb(1'b1, 5'd7, 32'h777);
        stall_wb(1'b0, 5'd5, 32'h999);
        load(1'b0, 12'h0FB, 32'h11C, 5'd5, 5'd5, 5'd2);
        stall_wb(1'b1, 5'd5, 32'h7777);

        // multi-write stall, last matching write wins, then release
        load(1'b1, 12'h0FD, 32'h120, 5'd5, 5'd6, 5'd3);
        stall_wb(1'b1, 5'd5, 32'h1);
        stall_wb(1'b1, 5'd5, 32'h2);
        stall_wb(1'b0, 5'd0, '0);
        stall_wb(1'b0, 5'd0, '0);
        load(1'b1, 12'h0FF, 32'h124, 5'd5, 5'd7, 5'd4);

        // async reset between edges while a valid instruction is stalled
        stall_wb(1'b0, 5'd0, '0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst.valid_e", XLEN'(valid_e), '0);
        chk("async_rst.ctrl_e",  XLEN'(ctrl_e),  '0);
        chk("async_rst.pc_e",    pc_e,           '0);
        chk("async_rst.rd1_e",   rd1_e,          '0);
        chk("async_rst.rd2_e",   rd2_e,          '0);
        chk("async_rst.rd_e",    XLEN'(rd_e),    '0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 12'h001, 32'h200, '0, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, '0);
        load(1'b1, 12'h003, 32'h204, 5'd3, 5'd5, 5'd6);

        // randomized traffic over a small register window to force hits
        for (int n = 0; n < 400; n++) begin
            drive(1'b0,
                  ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 80),
                  CTRL_W'($urandom), $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
